seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clocks per digit slot (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (reset=0 resets on next clk edge).
REQ-004 SHALL have port disp_data  input  32  hex value to display; digit i = disp_data[4i+3:4i].
REQ-005 SHALL have port dp_mask  input  8  decimal point request per digit, 1 = lit.
REQ-006 SHALL have port blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-007 SHALL have port an  output  8  digit anodes, active-low, one-hot-low when a digit is driven.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp  output  1  decimal point, active-low.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse marking a frame boundary and shadow load.

Function
REQ-011 SHALL keep prescaler cnt counting 0..SCAN_DIV-1; tick asserts when cnt==SCAN_DIV-1, and cnt wraps to 0 on the same edge.
REQ-012 SHALL keep digit index idx (3 bits) that increments on tick, wrapping 7->0.
REQ-013 SHALL, on tick with idx==7, load disp_data, dp_mask and blank_lz into shadow registers and pulse frame_done for exactly one cycle.
REQ-014 SHALL drive the display only from shadow registers; disp_data, dp_mask and blank_lz changes mid-frame have no visible effect until the next frame_done.
REQ-015 SHALL register an, seg and dp; they reflect (idx, shadow) with exactly one clock of latency.
REQ-016 SHALL, for the active digit, drive an[idx]=0 and all other anode bits=1.
REQ-017 SHALL encode nibbles active-low: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, gfedcba).
REQ-018 SHALL drive dp=0 when shadow dp_mask[idx]=1, else dp=1.
REQ-019 SHALL, with shadow blank_lz=1, blank digit idx (an=FF, seg=7F, dp=1) when idx!=0 and all shadow nibbles idx..7 are zero; digit 0 is never blanked.
REQ-020 SHALL produce a frame period of exactly 8*SCAN_DIV clocks; frame_done pulses are spaced exactly 8*SCAN_DIV clocks apart.

Reset
REQ-021 SHALL, when reset=0 at a clk edge, set cnt=0, idx=0, shadow data=0, shadow dp_mask=0, shadow blank_lz=0, an=FF, seg=7F, dp=1, frame_done=0.
REQ-022 SHALL, on reset asserted mid-frame, abandon the current frame; after release scanning restarts at digit 0 with shadow=0 (displays "00000000") until the first frame_done.
REQ-023 SHALL give reset priority over tick and frame load occurring on the same edge.

Structure
REQ-024 SHALL place the 16-entry nibble-to-segment constants, SEG_BLANK (7'h7F) and AN_OFF (8'hFF) in shared package seg7_pkg.
REQ-025 SHALL implement the nibble decode as combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out), instantiated once.
REQ-026 SHALL be 120-400 lines of RTL, no vendor primitives.

Verification (SCAN_DIV=4 unless stated)
REQ-027 Reset: hold reset=0 for 5 cycles -> an=FF, seg=7F, dp=1, frame_done=0 throughout; first output after release is an=FE, seg=40.
REQ-028 Decode: disp_data=32'h89ABCDEF, dp_mask=8'h01, after first frame_done -> digit0 an=FE seg=0E dp=0; digit7 an=7F seg=00 dp=1; digits 1..6 show E,d,C,b,A,9.
REQ-029 Tearing: change disp_data 89ABCDEF->12345678 while idx==3 -> remaining digits of that frame still show 8,9 pattern; new value visible only after next frame_done.
REQ-030 Blanking: blank_lz=1, disp_data=32'h000000A5 -> digits 7..2 an bit high and seg=7F; digit1 seg=08, digit0 seg=12; disp_data=0 -> digit0 seg=40, digits 7..1 blanked.
REQ-031 Timing: frame_done pulses one cycle wide every 32 clocks; each anode held low exactly 4 clocks; repeat with SCAN_DIV=2 -> every 16 clocks.
REQ-032 Mid-frame reset: assert reset=0 for one cycle at idx==5 -> next cycle an=FF, seg=7F; after release digit 0 shows 40 and frame_done arrives 32 clocks later.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 8-digit seven-segment scan driver.
package seg7_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a} for nibbles 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Display contents captured at a frame boundary.
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp_mask;
        logic        blank_lz;
    } shadow_t;

    // True when digit idx is a leading zero: idx is not the last digit and
    // every nibble from idx up to the most significant one is zero.
    function automatic logic is_leading_zero(input logic [31:0] data, input logic [2:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(idx) && data[4*i +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        return (idx != 3'd0) && all_zero;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the nibble.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver with per-frame shadowed
// contents, decimal points and optional leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_data,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0] seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    shadow_t         shadow_q;
    logic            tick;

    logic [3:0]      digit_nib;
    logic [6:0]      seg_dec;
    logic            digit_blank;
    logic [7:0]      an_d;
    logic [6:0]      seg_d;
    logic            dp_d;

    assign tick = (cnt_q == CntMax);

    // Prescaler, digit index, shadow load and frame pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shadow_q   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                cnt_q <= '0;
                idx_q <= idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    shadow_q.data     <= disp_data;
                    shadow_q.dp_mask  <= dp_mask;
                    shadow_q.blank_lz <= blank_lz;
                    frame_done        <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign digit_nib = shadow_q.data[4*idx_q +: 4];

    hex_to_seg7 u_dec (
        .nibble (digit_nib),
        .seg    (seg_dec)
    );

    // Next output values for the digit currently selected by idx.
    always_comb begin
        digit_blank = shadow_q.blank_lz && is_leading_zero(shadow_q.data, idx_q);
        an_d        = ~(8'b1 << idx_q);
        seg_d       = seg_dec;
        dp_d        = ~shadow_q.dp_mask[idx_q];
        if (digit_blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // Registered display outputs, one clock behind idx/shadow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
